// File: rtl/timer_compare.sv
// Compare/interrupt unit: raises a level irq when the timer count reaches CMP (one-shot or periodic).
// Bus slave: mem_ready pulses one cycle after an accepted request; irq lags PEND/IE by one cycle.
module timer_compare (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] count,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CMP    = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic        en_q, en_d;
  logic        per_q, per_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic        accept;
  logic        wr;
  logic [1:0]  sel;
  logic        cmp_wr;
  logic        period_wr;
  logic        ctrl_wr;
  logic        hit;
  logic        pend_set;
  logic        pend_clr;

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_instr, mem_addr[31:4], mem_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    accept    = mem_valid & enable & ~rdy_q;
    wr        = accept & (|mem_wstrb);
    sel       = mem_addr[3:2];
    cmp_wr    = wr & (sel == REG_CMP);
    period_wr = wr & (sel == REG_PERIOD);
    ctrl_wr   = wr & (sel == REG_CTRL);
    // Signed difference keeps the compare correct across count wrap.
    hit       = en_q & ($signed(count - cmp_q) >= 0);
    pend_set  = (state_q == ST_ARMED) & hit;
    pend_clr  = ctrl_wr & mem_wstrb[1] & mem_wdata[8];
  end

  always_comb begin
    state_d  = state_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    en_d     = en_q;
    per_d    = per_q;
    ie_d     = ie_q;
    rdy_d    = accept;
    rdata_d  = rdata_q;
    irq_d    = pend_q & ie_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          if (per_q) cmp_d = cmp_q + period_q;
          else       state_d = ST_FIRED;
        end
      end
      ST_FIRED: begin
        if (!en_q)       state_d = ST_IDLE;
        else if (cmp_wr) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus write lands after the periodic advance so software always wins.
    if (cmp_wr)    cmp_d    = merge_bytes(cmp_q, mem_wdata, mem_wstrb);
    if (period_wr) period_d = merge_bytes(period_q, mem_wdata, mem_wstrb);
    if (ctrl_wr && mem_wstrb[0]) begin
      en_d  = mem_wdata[0];
      per_d = mem_wdata[1];
      ie_d  = mem_wdata[2];
    end

    // A hit on the same edge as the W1C keeps PEND asserted.
    pend_d = (pend_q & ~pend_clr) | pend_set;

    if (accept) begin
      case (sel)
        REG_COUNT:  rdata_d = count;
        REG_CMP:    rdata_d = cmp_q;
        REG_PERIOD: rdata_d = period_q;
        REG_CTRL:   rdata_d = {23'd0, pend_q, 5'd0, ie_q, per_q, en_q};
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cmp_q    <= 32'd0;
      period_q <= 32'd0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      ie_q     <= 1'b0;
      pend_q   <= 1'b0;
      rdy_q    <= 1'b0;
      rdata_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      en_q     <= en_d;
      per_q    <= per_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      rdy_q    <= rdy_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign mem_ready = enable ? rdy_q   : 1'bz;
  assign mem_rdata = enable ? rdata_q : 32'bz;
  assign irq       = irq_q;

endmodule

// File: tb/tb_timer_compare.sv
// Directed bench for timer_compare: register table, then one-shot, periodic, wrap, collision and deselect sequences.
module tb_timer_compare;

  logic        clk;
  logic        resetn;
  logic [31:0] count;
  logic        enable;
  logic        mem_valid;
  wire         mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  wire  [31:0] mem_rdata;
  logic        irq;

  int n_cmp;
  int n_fail;

  timer_compare dut (
    .clk       (clk),
    .resetn    (resetn),
    .count     (count),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, output logic [31:0] rd);
    @(negedge clk);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = wdata;
    @(posedge clk);
    #1;
    check("ready_pulse_high", {31'd0, mem_ready}, 32'd1);
    rd = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("ready_pulse_low", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus(addr, 4'h0, 32'd0, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    logic [31:0] rd;
    bus(addr, wstrb, wdata, rd);
  endtask

  // Steps count by one per cycle and records the count present when irq is first seen high.
  task automatic ramp_watch(input logic [31:0] start, input int n,
                            output logic [31:0] first, output logic seen);
    seen  = 1'b0;
    first = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      count = start + 32'(i);
      @(posedge clk);
      #1;
      if (irq && !seen) begin
        seen  = 1'b1;
        first = count;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] first;
    logic        seen;
    logic [31:0] rd;

    n_cmp     = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    count     = 32'h1234_5678;
    enable    = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'd0;
    mem_addr  = 32'd0;

    vecs[0]  = '{32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 32'h1234_5678};
    vecs[1]  = '{32'h0000_0004, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[2]  = '{32'h0000_0008, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[3]  = '{32'h0000_000C, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[4]  = '{32'h0000_0004, 4'hF, 32'hA5A5_0001, 1'b0, 32'h0000_0000};
    vecs[5]  = '{32'h0000_0004, 4'h0, 32'h0000_0000, 1'b1, 32'hA5A5_0001};
    vecs[6]  = '{32'h0000_0004, 4'h2, 32'hFFFF_EEFF, 1'b0, 32'h0000_0000};
    vecs[7]  = '{32'h0000_0004, 4'h0, 32'h0000_0000, 1'b1, 32'hA5A5_EE01};
    vecs[8]  = '{32'h0000_0008, 4'hC, 32'h1234_0000, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0008, 4'h0, 32'h0000_0000, 1'b1, 32'h1234_0000};
    vecs[10] = '{32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 32'h1234_5678};
    vecs[12] = '{32'h0000_000C, 4'hF, 32'hFFFF_FEF2, 1'b0, 32'h0000_0000};
    vecs[13] = '{32'h0000_000C, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0002};
    vecs[14] = '{32'h0000_000C, 4'hF, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[15] = '{32'h0000_000C, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[16] = '{32'h1000_0004, 4'h0, 32'h0000_0000, 1'b1, 32'hA5A5_EE01};

    reset_dut();
    @(posedge clk);
    #1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);

    for (int i = 0; i < 17; i++) begin
      bus(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rd);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // One-shot
    reset_dut();
    count = 32'd0;
    wr(32'h4, 4'hF, 32'd100);
    wr(32'hC, 4'hF, 32'h5);
    ramp_watch(32'd90, 41, first, seen);
    check("oneshot_seen", {31'd0, seen}, 32'd1);
    check("oneshot_irq_count", first, 32'd101);
    rd_check("oneshot_ctrl_pend", 32'hC, 32'h105);
    wr(32'hC, 4'h2, 32'h100);
    check("oneshot_irq_drop", {31'd0, irq}, 32'd0);
    ramp_watch(32'd130, 80, first, seen);
    check("oneshot_no_refire", {31'd0, seen}, 32'd0);
    rd_check("oneshot_ctrl_after", 32'hC, 32'h5);

    // Periodic
    reset_dut();
    count = 32'd0;
    wr(32'h8, 4'hF, 32'd25);
    wr(32'h4, 4'hF, 32'd50);
    wr(32'hC, 4'hF, 32'h7);
    ramp_watch(32'd40, 21, first, seen);
    rd_check("per_cmp_1", 32'h4, 32'd75);
    rd_check("per_pend_1", 32'hC, 32'h107);
    wr(32'hC, 4'h2, 32'h100);
    rd_check("per_clr_1", 32'hC, 32'h7);
    ramp_watch(32'd61, 20, first, seen);
    rd_check("per_cmp_2", 32'h4, 32'd100);
    rd_check("per_pend_2", 32'hC, 32'h107);
    wr(32'hC, 4'h2, 32'h100);
    ramp_watch(32'd81, 25, first, seen);
    rd_check("per_cmp_3", 32'h4, 32'd125);
    rd_check("per_pend_3", 32'hC, 32'h107);
    check("per_irq", {31'd0, irq}, 32'd1);

    // Reset mid-operation
    reset_dut();
    check("midreset_irq", {31'd0, irq}, 32'd0);
    rd_check("midreset_cmp", 32'h4, 32'd0);
    rd_check("midreset_period", 32'h8, 32'd0);
    rd_check("midreset_ctrl", 32'hC, 32'd0);

    // Wrap
    reset_dut();
    count = 32'hFFFF_FFF0;
    wr(32'h4, 4'hF, 32'h10);
    wr(32'hC, 4'hF, 32'h5);
    ramp_watch(32'hFFFF_FFF0, 48, first, seen);
    check("wrap_seen", {31'd0, seen}, 32'd1);
    check("wrap_irq_count", first, 32'h11);
    rd_check("wrap_ctrl", 32'hC, 32'h105);

    // W1C on a hit edge (PERIOD=0 keeps hit asserted every cycle)
    reset_dut();
    count = 32'd1000;
    wr(32'h4, 4'hF, 32'd1000);
    wr(32'hC, 4'hF, 32'h7);
    repeat (3) @(posedge clk);
    wr(32'hC, 4'h2, 32'h100);
    check("w1c_collision_irq", {31'd0, irq}, 32'd1);
    rd_check("w1c_collision_ctrl", 32'hC, 32'h107);

    // CMP write on an advance edge
    @(negedge clk);
    count = 32'd1_000_000;
    wr(32'h8, 4'hF, 32'd5);
    wr(32'h4, 4'hF, 32'h7000_0000);
    rd_check("cmp_write_wins", 32'h4, 32'h7000_0000);

    // Deselected slave
    @(negedge clk);
    enable    = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = 32'h4;
    mem_wstrb = 4'hF;
    mem_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (!(mem_ready === 1'bz)) begin
      n_fail++;
      $display("FAIL deselect_ready_z: actual=%b required=z", mem_ready);
    end
    n_cmp++;
    if (!(mem_rdata === 32'bz)) begin
      n_fail++;
      $display("FAIL deselect_rdata_z: actual=%h required=z", mem_rdata);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    enable    = 1'b1;
    rd_check("deselect_cmp_unchanged", 32'h4, 32'h7000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
